// File: rtl/master_port_if.sv
// Serial system bus bundle seen from a master port: the parallel device request
// side plus the bit-serial link to the arbiter and slave ports.
interface master_port_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  dvalid;
  logic                  dmode;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  dready;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  ddone;
  logic                  derr;
  logic                  mbreq;
  logic                  mbgrant;
  logic                  mwdata;
  logic                  mmode;
  logic                  mvalid;
  logic                  mrdata;
  logic                  svalid;
  logic                  sready;
  logic                  ssplit;

  // The master port itself drives the request status and the serial outputs.
  modport master (
    input  dvalid, dmode, daddr, dwdata, mbgrant, mrdata, svalid, sready, ssplit,
    output dready, drdata, ddone, derr, mbreq, mwdata, mmode, mvalid
  );

  modport slave (
    output dvalid, dmode, daddr, dwdata, mbgrant, mrdata, svalid, sready, ssplit,
    input  dready, drdata, ddone, derr, mbreq, mwdata, mmode, mvalid
  );
endinterface

// File: rtl/master_port.sv
// Serial bus initiator: takes one parallel request, arbitrates for the bus,
// shifts address/write data out LSB first and collects serial read data.
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst,
  master_port_if.master bus
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  LAST_T = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic                  mode_r, mode_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [DATA_WIDTH-2:0] rdsh_r, rdsh_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [TO_W-1:0]       tcnt_r, tcnt_s;
  logic                  dready_r, dready_s;
  logic [DATA_WIDTH-1:0] drdata_r, drdata_s;
  logic                  ddone_r, ddone_s;
  logic                  derr_r, derr_s;
  logic                  mbreq_r, mbreq_s;
  logic                  mwdata_r, mwdata_s;
  logic                  mmode_r, mmode_s;
  logic                  mvalid_r, mvalid_s;

  // Next-state and next-output logic; serial outputs default to idle (mwdata=0).
  always_comb begin
    state_s  = state_r;
    mode_s   = mode_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    rdsh_s   = rdsh_r;
    cnt_s    = cnt_r;
    tcnt_s   = tcnt_r;
    dready_s = dready_r;
    drdata_s = drdata_r;
    ddone_s  = 1'b0;
    derr_s   = 1'b0;
    mbreq_s  = mbreq_r;
    mwdata_s = 1'b0;
    mmode_s  = mmode_r;
    mvalid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dready_s = 1'b1;
        if (bus.dvalid) begin
          mode_s   = bus.dmode;
          addr_s   = bus.daddr;
          wdata_s  = bus.dwdata;
          rdsh_s   = '0;
          cnt_s    = '0;
          tcnt_s   = '0;
          dready_s = 1'b0;
          mbreq_s  = 1'b1;
          state_s  = ST_REQ;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_REQ: begin
        mbreq_s = 1'b1;
        if (bus.mbgrant && bus.sready) begin
          state_s  = ST_ADDR;
          mmode_s  = mode_r;
          mvalid_s = 1'b1;
          mwdata_s = addr_r[0];
          addr_s   = {1'b0, addr_r[ADDR_WIDTH-1:1]};
          cnt_s    = '0;
        end else begin
          state_s  = ST_REQ;
        end
      end
      // cnt_r indexes the bit currently on the wire; the last one decides the exit.
      ST_ADDR: begin
        if (cnt_r == LAST_A) begin
          cnt_s = '0;
          if (mode_r) begin
            state_s  = ST_WDATA;
            mvalid_s = 1'b1;
            mwdata_s = wdata_r[0];
            wdata_s  = {1'b0, wdata_r[DATA_WIDTH-1:1]};
          end else begin
            state_s  = ST_RWAIT;
            tcnt_s   = '0;
          end
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          mvalid_s = 1'b1;
          mwdata_s = addr_r[0];
          addr_s   = {1'b0, addr_r[ADDR_WIDTH-1:1]};
        end
      end
      ST_WDATA: begin
        if (cnt_r == LAST_D) begin
          cnt_s   = '0;
          state_s = ST_DONE;
          ddone_s = 1'b1;
          mbreq_s = 1'b0;
          mmode_s = 1'b0;
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          mvalid_s = 1'b1;
          mwdata_s = wdata_r[0];
          wdata_s  = {1'b0, wdata_r[DATA_WIDTH-1:1]};
        end
      end
      // Read bits shift in from the top so the first bit lands in bit 0.
      ST_RWAIT: begin
        if (bus.svalid) begin
          tcnt_s = '0;
          if (cnt_r == LAST_D) begin
            drdata_s = {bus.mrdata, rdsh_r};
            state_s  = ST_DONE;
            ddone_s  = 1'b1;
            mbreq_s  = 1'b0;
            mmode_s  = 1'b0;
          end else begin
            rdsh_s   = {bus.mrdata, rdsh_r[DATA_WIDTH-2:1]};
            cnt_s    = cnt_r + CNT_W'(1);
          end
        end else if (bus.ssplit) begin
          tcnt_s = tcnt_r;
        end else if (tcnt_r == LAST_T) begin
          state_s = ST_DONE;
          ddone_s = 1'b1;
          derr_s  = 1'b1;
          mbreq_s = 1'b0;
          mmode_s = 1'b0;
        end else begin
          tcnt_s  = tcnt_r + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_s  = ST_IDLE;
        dready_s = 1'b1;
        mbreq_s  = 1'b0;
        mmode_s  = 1'b0;
      end
      default: begin
        state_s  = ST_IDLE;
        dready_s = 1'b1;
        mbreq_s  = 1'b0;
        mmode_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      mode_r   <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdsh_r   <= '0;
      cnt_r    <= '0;
      tcnt_r   <= '0;
      dready_r <= 1'b1;
      drdata_r <= '0;
      ddone_r  <= 1'b0;
      derr_r   <= 1'b0;
      mbreq_r  <= 1'b0;
      mwdata_r <= 1'b0;
      mmode_r  <= 1'b0;
      mvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      mode_r   <= mode_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      rdsh_r   <= rdsh_s;
      cnt_r    <= cnt_s;
      tcnt_r   <= tcnt_s;
      dready_r <= dready_s;
      drdata_r <= drdata_s;
      ddone_r  <= ddone_s;
      derr_r   <= derr_s;
      mbreq_r  <= mbreq_s;
      mwdata_r <= mwdata_s;
      mmode_r  <= mmode_s;
      mvalid_r <= mvalid_s;
    end
  end

  assign bus.dready = dready_r;
  assign bus.drdata = drdata_r;
  assign bus.ddone  = ddone_r;
  assign bus.derr   = derr_r;
  assign bus.mbreq  = mbreq_r;
  assign bus.mwdata = mwdata_r;
  assign bus.mmode  = mmode_r;
  assign bus.mvalid = mvalid_r;

endmodule
